// File: rtl/game_info_ctrl_if.sv
// rtl/game_info_ctrl_if.sv - event inputs and panel outputs of the snake game-phase controller
interface game_info_ctrl_if;
    logic       btn_ok;
    logic       eat_a;
    logic       eat_b;
    logic       crash_a;
    logic       crash_b;
    logic [3:0] state;
    logic [1:0] vict;
    logic [5:0] foodnum;
    logic [2:0] food_time_left;
    logic [5:0] score_a;
    logic [5:0] score_b;
    logic       food_respawn;

    modport master (
        output btn_ok, eat_a, eat_b, crash_a, crash_b,
        input  state, vict, foodnum, food_time_left, score_a, score_b, food_respawn
    );

    modport slave (
        input  btn_ok, eat_a, eat_b, crash_a, crash_b,
        output state, vict, foodnum, food_time_left, score_a, score_b, food_respawn
    );
endinterface

// File: rtl/game_info_ctrl.sv
// rtl/game_info_ctrl.sv - ready/play/pause/over sequencer with food budget, food timer, scores and winner
module game_info_ctrl #(
    parameter int FOOD_TOTAL  = 36,
    parameter int FOOD_LIFE   = 7,
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic            clk,
    input  logic            rst,
    game_info_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TICK_CYCLES - 1);
    localparam logic [5:0]       FOOD_INIT = 6'(FOOD_TOTAL);
    localparam logic [2:0]       LIFE_INIT = 3'(FOOD_LIFE);

    typedef enum logic [1:0] {S_READY, S_PLAY, S_PAUSE, S_OVER} state_t;

    state_t           r_fsm;
    logic [3:0]       r_state;
    logic [1:0]       r_vict;
    logic [5:0]       r_foodnum;
    logic [2:0]       r_ftl;
    logic [5:0]       r_score_a;
    logic [5:0]       r_score_b;
    logic             r_respawn;
    logic [CNT_W-1:0] r_cnt;

    logic       w_tick;
    logic       w_expire;
    logic       w_crash;
    logic       w_consume;
    logic [5:0] w_score_a_nxt;
    logic [5:0] w_score_b_nxt;
    logic [5:0] w_foodnum_nxt;
    logic [1:0] w_final_vict;

    assign w_tick        = (r_cnt == CNT_MAX);
    assign w_expire      = w_tick && (r_ftl == 3'd1);
    assign w_crash       = bus.crash_a || bus.crash_b;
    assign w_consume     = bus.eat_a || bus.eat_b || w_expire;
    assign w_score_a_nxt = (bus.eat_a && r_score_a != 6'd63) ? r_score_a + 6'd1 : r_score_a;
    assign w_score_b_nxt = (bus.eat_b && r_score_b != 6'd63) ? r_score_b + 6'd1 : r_score_b;
    assign w_foodnum_nxt = r_foodnum - 6'd1;
    // Winner on the last food is judged on the scores including this cycle's eats
    assign w_final_vict  = (w_score_a_nxt > w_score_b_nxt) ? 2'b10 :
                           (w_score_b_nxt > w_score_a_nxt) ? 2'b01 : 2'b11;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm     <= S_READY;
            r_state   <= 4'b0001;
            r_vict    <= 2'b00;
            r_foodnum <= FOOD_INIT;
            r_ftl     <= LIFE_INIT;
            r_score_a <= 6'd0;
            r_score_b <= 6'd0;
            r_respawn <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_respawn <= 1'b0;
            case (r_fsm)
                S_READY: begin
                    r_vict    <= 2'b00;
                    r_foodnum <= FOOD_INIT;
                    r_ftl     <= LIFE_INIT;
                    r_score_a <= 6'd0;
                    r_score_b <= 6'd0;
                    r_cnt     <= '0;
                    if (bus.btn_ok) begin
                        r_fsm     <= S_PLAY;
                        r_state   <= 4'b0010;
                        r_respawn <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (w_crash) begin
                        r_fsm   <= S_OVER;
                        r_state <= 4'b1000;
                        r_vict  <= {bus.crash_b, bus.crash_a};
                    end else if (w_consume) begin
                        r_score_a <= w_score_a_nxt;
                        r_score_b <= w_score_b_nxt;
                        r_foodnum <= w_foodnum_nxt;
                        r_ftl     <= LIFE_INIT;
                        r_cnt     <= '0;
                        if (w_foodnum_nxt == 6'd0) begin
                            r_fsm   <= S_OVER;
                            r_state <= 4'b1000;
                            r_vict  <= w_final_vict;
                        end else begin
                            r_respawn <= 1'b1;
                            if (bus.btn_ok) begin
                                r_fsm   <= S_PAUSE;
                                r_state <= 4'b0100;
                            end
                        end
                    end else if (bus.btn_ok) begin
                        // Timer freezes on the pause cycle itself, so a tick due now lands right after resume
                        r_fsm   <= S_PAUSE;
                        r_state <= 4'b0100;
                    end else if (w_tick) begin
                        r_ftl <= r_ftl - 3'd1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (bus.btn_ok) begin
                        r_fsm   <= S_PLAY;
                        r_state <= 4'b0010;
                    end
                end
                S_OVER: begin
                    if (bus.btn_ok) begin
                        r_fsm     <= S_READY;
                        r_state   <= 4'b0001;
                        r_vict    <= 2'b00;
                        r_foodnum <= FOOD_INIT;
                        r_ftl     <= LIFE_INIT;
                        r_score_a <= 6'd0;
                        r_score_b <= 6'd0;
                        r_cnt     <= '0;
                    end
                end
                default: begin
                    r_fsm   <= S_READY;
                    r_state <= 4'b0001;
                end
            endcase
        end
    end

    assign bus.state          = r_state;
    assign bus.vict           = r_vict;
    assign bus.foodnum        = r_foodnum;
    assign bus.food_time_left = r_ftl;
    assign bus.score_a        = r_score_a;
    assign bus.score_b        = r_score_b;
    assign bus.food_respawn   = r_respawn;
endmodule

// File: tb/tb_game_info_ctrl.sv
// tb/tb_game_info_ctrl.sv - scoreboard bench: expected output changes queued with their cycle, monitor pops on each change
module tb_game_info_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    game_info_ctrl_if bus();

    game_info_ctrl #(
        .FOOD_TOTAL (4),
        .FOOD_LIFE  (3),
        .TICK_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] vict;
        logic [5:0] fn;
        logic [2:0] ftl;
        logic [5:0] sa;
        logic [5:0] sb;
        logic       resp;
    } snap_t;

    typedef struct {
        int    cyc;
        snap_t s;
    } exp_t;

    exp_t  exp_q[$];
    snap_t cur;
    snap_t prev;
    snap_t core_cur;
    snap_t core_prev;
    logic  have_prev = 1'b0;

    function automatic void expect_at(int c, logic [3:0] st, logic [1:0] v, logic [5:0] fn,
                                      logic [2:0] ftl, logic [5:0] sa, logic [5:0] sb, logic resp);
        exp_t e;
        e.cyc = c;
        e.s   = '{st: st, vict: v, fn: fn, ftl: ftl, sa: sa, sb: sb, resp: resp};
        exp_q.push_back(e);
    endfunction

    task automatic wait_to(int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drive(int c, logic btn, logic ea, logic eb, logic ca, logic cb);
        wait_to(c);
        bus.btn_ok  = btn;
        bus.eat_a   = ea;
        bus.eat_b   = eb;
        bus.crash_a = ca;
        bus.crash_b = cb;
        wait_to(c + 1);
        bus.btn_ok  = 1'b0;
        bus.eat_a   = 1'b0;
        bus.eat_b   = 1'b0;
        bus.crash_a = 1'b0;
        bus.crash_b = 1'b0;
    endtask

    // Monitor: any change of the panel outputs is one DUT response to match against the queue
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cur = {bus.state, bus.vict, bus.foodnum, bus.food_time_left,
                   bus.score_a, bus.score_b, bus.food_respawn};
            if (cur.resp) begin
                checks++;
                if (have_prev && prev.resp) begin
                    errors++;
                    $display("FAIL respawn_width cyc=%0d: respawn high on consecutive cycles, required single-cycle pulse", cyc);
                end
            end
            core_cur       = cur;
            core_cur.resp  = 1'b0;
            core_prev      = prev;
            core_prev.resp = 1'b0;
            if (!have_prev || core_cur != core_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.s != cur) begin
                        errors++;
                        $display("FAIL event cyc=%0d got st=%b vict=%b fn=%0d ftl=%0d sa=%0d sb=%0d resp=%b | required cyc=%0d st=%b vict=%b fn=%0d ftl=%0d sa=%0d sb=%0d resp=%b",
                                 cyc, cur.st, cur.vict, cur.fn, cur.ftl, cur.sa, cur.sb, cur.resp,
                                 e.cyc, e.s.st, e.s.vict, e.s.fn, e.s.ftl, e.s.sa, e.s.sb, e.s.resp);
                    end
                end
            end
            prev      = cur;
            have_prev = 1'b1;
        end
    end

    initial begin
        bus.btn_ok  = 1'b0;
        bus.eat_a   = 1'b0;
        bus.eat_b   = 1'b0;
        bus.crash_a = 1'b0;
        bus.crash_b = 1'b0;

        // Reset state, then start
        expect_at(1, 4'b0001, 2'b00, 6'd4, 3'd3, 6'd0, 6'd0, 1'b0);
        wait_to(2);
        rst = 1'b0;
        expect_at(4, 4'b0010, 2'b00, 6'd4, 3'd3, 6'd0, 6'd0, 1'b1);
        // Expiry with no eats, then a second food running down
        expect_at(8,  4'b0010, 2'b00, 6'd4, 3'd2, 6'd0, 6'd0, 1'b0);
        expect_at(12, 4'b0010, 2'b00, 6'd4, 3'd1, 6'd0, 6'd0, 1'b0);
        expect_at(16, 4'b0010, 2'b00, 6'd3, 3'd3, 6'd0, 6'd0, 1'b1);
        expect_at(20, 4'b0010, 2'b00, 6'd3, 3'd2, 6'd0, 6'd0, 1'b0);
        expect_at(24, 4'b0010, 2'b00, 6'd3, 3'd1, 6'd0, 6'd0, 1'b0);
        drive(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Eat A on the expiry tick: one consume
        expect_at(28, 4'b0010, 2'b00, 6'd2, 3'd3, 6'd1, 6'd0, 1'b1);
        drive(27, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Pause at tick count 2, ignored events, resume, tick two cycles later
        expect_at(31, 4'b0100, 2'b00, 6'd2, 3'd3, 6'd1, 6'd0, 1'b0);
        drive(30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(35, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(45, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_at(52, 4'b0010, 2'b00, 6'd2, 3'd3, 6'd1, 6'd0, 1'b0);
        expect_at(54, 4'b0010, 2'b00, 6'd2, 3'd2, 6'd1, 6'd0, 1'b0);
        drive(51, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-pause
        expect_at(56, 4'b0100, 2'b00, 6'd2, 3'd2, 6'd1, 6'd0, 1'b0);
        drive(55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(59, 4'b0001, 2'b00, 6'd4, 3'd3, 6'd0, 6'd0, 1'b0);
        wait_to(58);
        rst = 1'b1;
        wait_to(59);
        rst = 1'b0;

        // Simultaneous crash with eat_b; OVER holds; back to READY
        expect_at(62, 4'b0010, 2'b00, 6'd4, 3'd3, 6'd0, 6'd0, 1'b1);
        drive(61, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(64, 4'b0010, 2'b00, 6'd3, 3'd3, 6'd1, 6'd0, 1'b1);
        drive(63, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(66, 4'b1000, 2'b11, 6'd3, 3'd3, 6'd1, 6'd0, 1'b0);
        drive(65, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(68, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(71, 4'b0001, 2'b00, 6'd4, 3'd3, 6'd0, 6'd0, 1'b0);
        drive(70, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Last food eaten by B levels the score: draw, no respawn
        expect_at(73, 4'b0010, 2'b00, 6'd4, 3'd3, 6'd0, 6'd0, 1'b1);
        drive(72, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(75, 4'b0010, 2'b00, 6'd3, 3'd3, 6'd1, 6'd0, 1'b1);
        drive(74, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(77, 4'b0010, 2'b00, 6'd2, 3'd3, 6'd1, 6'd1, 1'b1);
        drive(76, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(79, 4'b0010, 2'b00, 6'd1, 3'd3, 6'd2, 6'd1, 1'b1);
        drive(78, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_at(81, 4'b1000, 2'b11, 6'd0, 3'd3, 6'd2, 6'd2, 1'b0);
        drive(80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Consume together with btn_ok pauses after the consume; crash_b alone gives A the win
        expect_at(84, 4'b0001, 2'b00, 6'd4, 3'd3, 6'd0, 6'd0, 1'b0);
        drive(83, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(86, 4'b0010, 2'b00, 6'd4, 3'd3, 6'd0, 6'd0, 1'b1);
        drive(85, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(88, 4'b0100, 2'b00, 6'd3, 3'd3, 6'd0, 6'd1, 1'b1);
        drive(87, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_at(90, 4'b0010, 2'b00, 6'd3, 3'd3, 6'd0, 6'd1, 1'b0);
        drive(89, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(92, 4'b1000, 2'b10, 6'd3, 3'd3, 6'd0, 6'd1, 1'b0);
        drive(91, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // crash_a alone gives B the win
        expect_at(94, 4'b0001, 2'b00, 6'd4, 3'd3, 6'd0, 6'd0, 1'b0);
        drive(93, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(96, 4'b0010, 2'b00, 6'd4, 3'd3, 6'd0, 6'd0, 1'b1);
        drive(95, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_at(98, 4'b1000, 2'b01, 6'd4, 3'd3, 6'd0, 6'd0, 1'b0);
        drive(97, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        wait_to(104);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got %0d expected responses never seen, required 0 (next due cyc=%0d)",
                     exp_q.size(), exp_q[0].cyc);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
